my_addsub_serial: RTL and testbench

//  Parametrised multi-cycle add/subtract unit for the CPU datapath; the successor to the fixed 32-bit subtractor.

---
 rtl/my_addsub_serial_pkg.sv | 18 +
 rtl/my_addsub_serial_rc_adder_chunk.sv | 27 ++
 rtl/my_addsub_serial.sv | 122 ++++++++++++
 tb/tb_my_addsub_serial.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/my_addsub_serial_pkg.sv
// Shared definitions for the chunk-serial add/subtract unit: FSM states, mode codes
// and a counter-width helper.
package my_addsub_serial_pkg;

  typedef enum logic {
    Idle = 1'b0,
    Run  = 1'b1
  } state_e;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int unsigned cntWidth(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/my_addsub_serial_rc_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its top bit
// so the caller can derive signed overflow.
module rc_adder_chunk #(
  parameter int unsigned CHUNK = 8
) (
  output logic [CHUNK-1:0] sum,
  output logic             cOut,
  output logic             cMsbIn,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cIn
);

  always_comb begin
    logic carry;
    carry  = cIn;
    sum    = '0;
    cMsbIn = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      cMsbIn = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cOut = carry;
  end

endmodule

// File: rtl/my_addsub_serial.sv
// Multi-cycle add/subtract: computes A + (sub ? ~B : B) + sub, CHUNK bits per clock,
// LSB chunk first, through one shared ripple adder.
module my_addsub_serial
  import my_addsub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             cOut,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = cntWidth(NCHUNK);

  state_e            stateQ, stateD;
  logic [CntW-1:0]   cntQ;
  logic [WIDTH-1:0]  aQ, bQ, accQ, accD, resultQ;
  logic              carryQ, doneQ, cOutQ, ovfQ, zeroQ, negQ;
  logic [CHUNK-1:0]  sumC;
  logic              carryC, cMsbC;
  logic              accept, last;

  assign accept = start && (stateQ == Idle);
  assign last   = (stateQ == Run) && (cntQ == CntW'(NCHUNK - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stateQ <= Idle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      Idle:    if (start) stateD = Run;
      Run:     if (last) stateD = Idle;
      default: stateD = Idle;
    endcase
  end

  always_comb begin
    busy = (stateQ == Run);
  end

  rc_adder_chunk #(
    .CHUNK(CHUNK)
  ) uAdder (
    .sum   (sumC),
    .cOut  (carryC),
    .cMsbIn(cMsbC),
    .a     (aQ[CHUNK-1:0]),
    .b     (bQ[CHUNK-1:0]),
    .cIn   (carryQ)
  );

  // Working accumulator keeps Result stable until the whole operation has finished.
  always_comb begin
    accD = accQ;
    accD[cntQ*CHUNK +: CHUNK] = sumC;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cntQ    <= '0;
      aQ      <= '0;
      bQ      <= '0;
      accQ    <= '0;
      carryQ  <= 1'b0;
      resultQ <= '0;
      doneQ   <= 1'b0;
      cOutQ   <= 1'b0;
      ovfQ    <= 1'b0;
      zeroQ   <= 1'b0;
      negQ    <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (accept) begin
        aQ     <= A;
        bQ     <= B ^ {WIDTH{sub == OpSub}};
        carryQ <= sub;
        cntQ   <= '0;
      end else if (stateQ == Run) begin
        aQ     <= aQ >> CHUNK;
        bQ     <= bQ >> CHUNK;
        carryQ <= carryC;
        cntQ   <= cntQ + 1'b1;
        accQ   <= accD;
        if (last) begin
          cntQ    <= '0;
          resultQ <= accD;
          doneQ   <= 1'b1;
          cOutQ   <= carryC;
          ovfQ    <= cMsbC ^ carryC;
          zeroQ   <= (accD == '0);
          negQ    <= accD[WIDTH-1];
        end
      end
    end
  end

  assign done     = doneQ;
  assign Result   = resultQ;
  assign cOut     = cOutQ;
  assign overflow = ovfQ;
  assign zero     = zeroQ;
  assign negative = negQ;

endmodule

// File: tb/tb_my_addsub_serial.sv
// Bench for my_addsub_serial: three instances (CHUNK 8, 32, 4) share stimulus; checks
// timing, results and flags against a table and an arithmetic reference model.
module tb_my_addsub_serial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        startV [3];
  logic        busyV  [3];
  logic        doneV  [3];
  logic        cOutV  [3];
  logic        ovfV   [3];
  logic        zeroV  [3];
  logic        negV   [3];
  logic [31:0] resV   [3];
  logic [31:0] prevRes[3];

  int nCmp = 0;
  int nErr = 0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eRes;
    logic        eC, eV, eZ, eN;
  } vec_t;

  always #5 clock = ~clock;

  my_addsub_serial #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(startV[0]), .sub(sub), .A(A), .B(B),
    .busy(busyV[0]), .done(doneV[0]), .Result(resV[0]), .cOut(cOutV[0]),
    .overflow(ovfV[0]), .zero(zeroV[0]), .negative(negV[0])
  );
  my_addsub_serial #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .start(startV[1]), .sub(sub), .A(A), .B(B),
    .busy(busyV[1]), .done(doneV[1]), .Result(resV[1]), .cOut(cOutV[1]),
    .overflow(ovfV[1]), .zero(zeroV[1]), .negative(negV[1])
  );
  my_addsub_serial #(.WIDTH(32), .CHUNK(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(startV[2]), .sub(sub), .A(A), .B(B),
    .busy(busyV[2]), .done(doneV[2]), .Result(resV[2]), .cOut(cOutV[2]),
    .overflow(ovfV[2]), .zero(zeroV[2]), .negative(negV[2])
  );

  function automatic int nch(int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: plain 33-bit arithmetic; returns {res, c, v, z, n}.
  function automatic logic [35:0] model(logic s, logic [31:0] a, logic [31:0] b);
    logic [31:0] bb;
    logic [32:0] full;
    logic        v;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    v    = (a[31] == bb[31]) && (full[31] != a[31]);
    return {full[31:0], full[32], v, (full[31:0] == 32'd0), full[31]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setStart(input logic v);
    for (int i = 0; i < 3; i++) startV[i] = v;
  endtask

  task automatic chkAllZero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s i%0d outputs", tag, i),
          {busyV[i], doneV[i], cOutV[i], ovfV[i], zeroV[i], negV[i], resV[i]}, 64'd0);
    end
  endtask

  // Runs one operation on all instances; optionally pulses instance 0's start while busy.
  task automatic doOp(input string tag, input vec_t v, input int pulseAt);
    @(negedge clock);
    sub = v.s; A = v.a; B = v.b;
    setStart(1'b1);
    @(posedge clock);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        int n;
        n = nch(i);
        chk($sformatf("%s i%0d c%0d busy/done", tag, i, k),
            {busyV[i], doneV[i]}, {(k <= n), (k == n + 1)});
        if (k == n + 1) begin
          chk($sformatf("%s i%0d result", tag, i), resV[i], v.eRes);
          chk($sformatf("%s i%0d flags cvzn", tag, i),
              {cOutV[i], ovfV[i], zeroV[i], negV[i]}, {v.eC, v.eV, v.eZ, v.eN});
          prevRes[i] = v.eRes;
        end else if (k <= n) begin
          chk($sformatf("%s i%0d c%0d held", tag, i, k), resV[i], prevRes[i]);
        end
      end
      A = $urandom; B = $urandom; sub = 1'($urandom);
      setStart(1'b0);
      if (k == pulseAt) startV[0] = 1'b1;
    end
  endtask

  vec_t tbl[7];

  initial begin
    logic [35:0] m;
    vec_t        r;
    setStart(1'b0);
    for (int i = 0; i < 3; i++) prevRes[i] = '0;

    tbl[0] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'd0,         32'd0,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chkAllZero("reset");
    reset_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      doOp($sformatf("tbl%0d", t), tbl[t], (t == 4) ? 2 : 0);
    end

    for (int t = 0; t < 20; t++) begin
      r.s = 1'($urandom); r.a = $urandom; r.b = $urandom;
      if (t == 0) r.b = r.a;
      m = model(r.s, r.a, r.b);
      {r.eRes, r.eC, r.eV, r.eZ, r.eN} = m;
      doOp($sformatf("rnd%0d", t), r, 0);
    end

    // Reset in the second RUN cycle abandons the operation without a done pulse.
    @(negedge clock);
    sub = 1'b1; A = 32'd5; B = 32'd7;
    setStart(1'b1);
    @(posedge clock);
    @(negedge clock);
    setStart(1'b0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chkAllZero("midreset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) prevRes[i] = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("postreset i%0d c%0d busy/done", i, k), {busyV[i], doneV[i]}, 2'b00);
      end
    end
    doOp("afterreset", tbl[0], 0);

    // Back-to-back: instance 0 restarts in its done cycle.
    @(negedge clock);
    sub = 1'b1; A = 32'd5; B = 32'd7;
    setStart(1'b1);
    @(posedge clock);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      setStart(1'b0);
      if (k == 5) begin
        chk("b2b first done", {doneV[0], resV[0]}, {1'b1, 32'hFFFF_FFFE});
        sub = 1'b0; A = 32'h7FFF_FFFF; B = 32'd1;
        startV[0] = 1'b1;
      end else if (k == 6) begin
        chk("b2b accepted", {busyV[0], doneV[0], resV[0]}, {2'b10, 32'hFFFF_FFFE});
        A = $urandom; B = $urandom;
      end else if (k == 10) begin
        chk("b2b second done", {doneV[0], resV[0]}, {1'b1, 32'h8000_0000});
        chk("b2b second flags", {cOutV[0], ovfV[0], zeroV[0], negV[0]}, 4'b0101);
      end
    end
    prevRes[0] = 32'h8000_0000;
    prevRes[1] = 32'hFFFF_FFFE;
    prevRes[2] = 32'hFFFF_FFFE;
    doOp("final", tbl[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
